// File: rtl/aoi322_cone_pipe_pkg.sv
// Shared constants for the AOI322 cone pipeline: lane-function truth tables
// and the legal parameter ranges for the top level.
package aoi322_cone_pipe_pkg;

   localparam int WIDTH_MIN  = 1;
   localparam int WIDTH_MAX  = 64;
   localparam int STAGES_MIN = 1;
   localparam int STAGES_MAX = 4;

   // Indexed by {n_4, n_3, n_2, n_1, n_0}; a set bit means the lane output is 1.
   localparam logic [31:0] AOI322_TT     = 32'h2A00_3F00;
   localparam logic [31:0] AOI322_TT_INV = ~AOI322_TT;

   function automatic logic [4:0] lane_index(input logic n0, input logic n1,
                                             input logic n2, input logic n3,
                                             input logic n4);
      return {n4, n3, n2, n1, n0};
   endfunction

endpackage

// File: rtl/aoi322_lane_fn.sv
// Combinational per-lane AOI322 cone with optional output inversion,
// evaluated by table lookup so both polarities share one index path.
module aoi322_lane_fn
   import aoi322_cone_pipe_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] n_0_i,
   input  logic [WIDTH-1:0] n_1_i,
   input  logic [WIDTH-1:0] n_2_i,
   input  logic [WIDTH-1:0] n_3_i,
   input  logic [WIDTH-1:0] n_4_i,
   input  logic             inv_mode_i,
   output logic [WIDTH-1:0] res_o
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      logic [4:0] idx;
      assign idx      = lane_index(n_0_i[i], n_1_i[i], n_2_i[i], n_3_i[i], n_4_i[i]);
      assign res_o[i] = inv_mode_i ? AOI322_TT_INV[idx] : AOI322_TT[idx];
   end

endmodule

// File: rtl/aoi322_cone_pipe.sv
// Elastic STAGES-deep pipeline carrying the AOI322 lane results, with a
// saturating count of delivered nonzero results.
module aoi322_cone_pipe
   import aoi322_cone_pipe_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] n_0,
   input  logic [WIDTH-1:0] n_1,
   input  logic [WIDTH-1:0] n_2,
   input  logic [WIDTH-1:0] n_3,
   input  logic [WIDTH-1:0] n_4,
   input  logic             inv_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] n_5,
   output logic [CNT_W-1:0] hit_cnt,
   input  logic             cnt_clr
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
       STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_param_check
      $error("aoi322_cone_pipe: WIDTH or STAGES out of range");
   end

   logic [WIDTH-1:0] laneRes;
   logic [STAGES-1:0] slotValid;
   logic [STAGES-1:0] slotAdv;
   logic [WIDTH-1:0]  slotData [STAGES];
   logic              accept;
   logic              deliver;
   logic [CNT_W-1:0]  hitCnt_q;
   logic [CNT_W-1:0]  hitCnt_d;

   aoi322_lane_fn #(
      .WIDTH(WIDTH)
   ) u_lane_fn (
      .n_0_i      (n_0),
      .n_1_i      (n_1),
      .n_2_i      (n_2),
      .n_3_i      (n_3),
      .n_4_i      (n_4),
      .inv_mode_i (inv_mode),
      .res_o      (laneRes)
   );

   // Advance resolves from the output end backwards, so only valid bits and
   // out_ready feed it; in_valid never reaches in_ready.
   always_comb begin
      slotAdv = '0;
      slotAdv[STAGES-1] = slotValid[STAGES-1] & out_ready;
      for (int s = STAGES - 2; s >= 0; s--) begin
         slotAdv[s] = slotValid[s] & (~slotValid[s+1] | slotAdv[s+1]);
      end
   end

   assign in_ready = rst_n & (~slotValid[0] | slotAdv[0]);
   assign accept   = in_valid & in_ready;

   for (genvar s = 0; s < STAGES; s++) begin : g_slot
      logic             valid_q;
      logic             valid_d;
      logic             load;
      logic [WIDTH-1:0] data_q;
      logic [WIDTH-1:0] data_d;

      if (s == 0) begin : g_head
         assign load   = accept;
         assign data_d = laneRes;
      end else begin : g_body
         assign load   = slotAdv[s-1];
         assign data_d = slotData[s-1];
      end

      assign valid_d = load | (valid_q & ~slotAdv[s]);

      // Data only loads alongside a valid vector, so idle slots never toggle.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else begin
            valid_q <= valid_d;
            if (load) begin
               data_q <= data_d;
            end
         end
      end

      assign slotValid[s] = valid_q;
      assign slotData[s]  = data_q;
   end

   assign out_valid = slotValid[STAGES-1];
   assign n_5       = slotData[STAGES-1];
   assign deliver   = out_valid & out_ready;

   always_comb begin
      hitCnt_d = hitCnt_q;
      if (cnt_clr) begin
         hitCnt_d = '0;
      end else if (deliver && (|n_5) && (hitCnt_q != {CNT_W{1'b1}})) begin
         hitCnt_d = hitCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hitCnt_q <= '0;
      end else begin
         hitCnt_q <= hitCnt_d;
      end
   end

   assign hit_cnt = hitCnt_q;

endmodule

// File: tb/tb_aoi322_cone_pipe.sv
// Self-checking bench for aoi322_cone_pipe: directed scenarios plus random
// traffic compared every cycle against a queue-based behavioural model.
module tb_aoi322_cone_pipe;

   localparam int WIDTH  = 4;
   localparam int STAGES = 2;
   localparam int CNT_W  = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   localparam logic [WIDTH-1:0] V0 = 4'b1000;
   localparam logic [WIDTH-1:0] V1 = 4'b1000;
   localparam logic [WIDTH-1:0] V2 = 4'b1000;
   localparam logic [WIDTH-1:0] V3 = 4'b1101;
   localparam logic [WIDTH-1:0] V4 = 4'b0100;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] n_0, n_1, n_2, n_3, n_4;
   logic             inv_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] n_5;
   logic [CNT_W-1:0] hit_cnt;
   logic             cnt_clr;

   int nCompared = 0;
   int nMismatch = 0;
   int cyc = 0;

   aoi322_cone_pipe #(
      .WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .n_0(n_0), .n_1(n_1), .n_2(n_2), .n_3(n_3), .n_4(n_4),
      .inv_mode(inv_mode), .out_valid(out_valid), .out_ready(out_ready),
      .n_5(n_5), .hit_cnt(hit_cnt), .cnt_clr(cnt_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // The lane rule written straight from the unreduced boolean form.
   function automatic logic [WIDTH-1:0] modelFn(input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                                                input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] a3,
                                                input logic [WIDTH-1:0] a4, input logic inv);
      logic [WIDTH-1:0] r;
      r = ~((a1 & a2 & a3) | (a4 & ~a0) | (~(a0 & a3) & ~a3));
      return inv ? ~r : r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                                input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] a3,
                                input logic [WIDTH-1:0] a4, input logic inv, input logic ordy,
                                input logic clr);
      in_valid  = v;
      n_0       = a0;
      n_1       = a1;
      n_2       = a2;
      n_3       = a3;
      n_4       = a4;
      inv_mode  = inv;
      out_ready = ordy;
      cnt_clr   = clr;
   endtask

   task automatic randomOperands();
      n_0      = WIDTH'($urandom);
      n_1      = WIDTH'($urandom);
      n_2      = WIDTH'($urandom);
      n_3      = WIDTH'($urandom);
      n_4      = WIDTH'($urandom);
      inv_mode = 1'($urandom);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Reference model: in-flight vectors in order, with the cycle each was accepted.
   typedef struct {
      logic [WIDTH-1:0] val;
      int               acc;
   } item_t;

   item_t            q[$];
   int               modelCnt = 0;
   int               lastLow = -1;
   bit               prevHold = 1'b0;
   logic [WIDTH-1:0] prevN5 = '0;
   int               delivered = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
         checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
         checkOutput("rst_n_5", 64'(n_5), 64'(0));
         checkOutput("rst_hit_cnt", 64'(hit_cnt), 64'(0));
         q.delete();
         modelCnt = 0;
         prevHold = 1'b0;
         lastLow  = cyc;
      end else begin
         checkOutput("hit_cnt", 64'(hit_cnt), 64'(modelCnt));
         checkOutput("in_ready", 64'(in_ready), 64'((q.size() < STAGES) || out_ready));
         if (prevHold) begin
            checkOutput("hold_out_valid", 64'(out_valid), 64'(1));
            checkOutput("hold_n_5", 64'(n_5), 64'(prevN5));
         end
         if (q.size() == 0) begin
            checkOutput("idle_out_valid", 64'(out_valid), 64'(0));
         end else begin
            if (cyc < q[0].acc + STAGES)
               checkOutput("early_out_valid", 64'(out_valid), 64'(0));
            else if (cyc == q[0].acc + STAGES && lastLow < q[0].acc)
               checkOutput("latency_out_valid", 64'(out_valid), 64'(1));
            if (out_valid)
               checkOutput("n_5_data", 64'(n_5), 64'(q[0].val));
         end
         if (out_valid && out_ready && q.size() > 0) begin
            if (q[0].val != '0 && modelCnt < CNT_MAX) modelCnt++;
            void'(q.pop_front());
            delivered++;
         end
         if (cnt_clr) modelCnt = 0;
         if (in_valid && in_ready) q.push_back('{modelFn(n_0, n_1, n_2, n_3, n_4, inv_mode), cyc});
         prevHold = out_valid && !out_ready;
         prevN5   = n_5;
         if (!out_ready) lastLow = cyc;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit, got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int k, base, acc, run, maxRun, seen, bound;

      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      checkOutput("in_ready_after_reset", 64'(in_ready), 64'(1));

      // Hand-computed pins on the model itself.
      checkOutput("model_pin_normal", 64'(modelFn(V0, V1, V2, V3, V4, 1'b0)), 64'(4'b0001));
      checkOutput("model_pin_inv", 64'(modelFn(V0, V1, V2, V3, V4, 1'b1)), 64'(4'b1110));
      checkOutput("model_pin_ones", 64'(modelFn(4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0)), 64'(4'b0000));
      checkOutput("model_pin_n3only", 64'(modelFn(4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0)), 64'(4'b1111));

      // Directed vector, normal then inverted polarity.
      nextCycle();
      applyStimulus(1'b1, V0, V1, V2, V3, V4, 1'b0, 1'b1, 1'b0);
      nextCycle();
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("req032_not_yet_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
      checkOutput("req032_out_valid", 64'(out_valid), 64'(1));
      checkOutput("req032_n_5", 64'(n_5), 64'(4'b0001));
      @(negedge clk);
      checkOutput("req032_hit_cnt", 64'(hit_cnt), 64'(1));

      nextCycle();
      applyStimulus(1'b1, V0, V1, V2, V3, V4, 1'b1, 1'b1, 1'b0);
      nextCycle();
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("req033_out_valid", 64'(out_valid), 64'(1));
      checkOutput("req033_n_5", 64'(n_5), 64'(4'b1110));
      @(negedge clk);
      checkOutput("req033_hit_cnt", 64'(hit_cnt), 64'(2));

      // Counter clear, then saturation with five nonzero results.
      nextCycle();
      cnt_clr = 1'b1;
      nextCycle();
      cnt_clr = 1'b0;
      @(negedge clk);
      checkOutput("req036_cleared", 64'(hit_cnt), 64'(0));
      for (int i = 0; i < 5; i++) begin
         nextCycle();
         applyStimulus(1'b1, V0, V1, V2, V3, V4, 1'b0, 1'b1, 1'b0);
      end
      nextCycle();
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("req036_saturated", 64'(hit_cnt), 64'(3));

      // Clear wins over a same-cycle hit.
      nextCycle();
      applyStimulus(1'b1, V0, V1, V2, V3, V4, 1'b0, 1'b0, 1'b0);
      nextCycle();
      in_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      checkOutput("req036_wait_out_valid", 64'(seen), 64'(1));
      nextCycle();
      out_ready = 1'b1;
      cnt_clr   = 1'b1;
      nextCycle();
      cnt_clr   = 1'b0;
      @(negedge clk);
      checkOutput("req036_clear_priority", 64'(hit_cnt), 64'(0));

      // Backpressure: six vectors offered with out_ready low at first.
      k = 0;
      base = delivered;
      for (int i = 0; i < 40 && k < 6; i++) begin
         nextCycle();
         in_valid  = 1'b1;
         randomOperands();
         out_ready = (i >= 6);
         @(negedge clk);
         if (in_ready) k++;
         if (i == 5) begin
            checkOutput("req034_accepts_when_full", 64'(k), 64'(2));
            checkOutput("req034_in_ready_low", 64'(in_ready), 64'(0));
         end
      end
      nextCycle();
      in_valid = 1'b0;
      checkOutput("req034_all_accepted", 64'(k), 64'(6));
      for (int i = 0; i < 20 && (delivered - base) < 6; i++) @(negedge clk);
      checkOutput("req034_all_delivered", 64'(delivered - base), 64'(6));

      // Sustained throughput.
      acc = 0; run = 0; maxRun = 0;
      base = delivered;
      out_ready = 1'b1;
      for (int i = 0; i < 20 + STAGES; i++) begin
         nextCycle();
         in_valid = (i < 20);
         randomOperands();
         @(negedge clk);
         if (in_valid && in_ready) acc++;
         if (out_valid) run++; else run = 0;
         if (run > maxRun) maxRun = run;
      end
      nextCycle();
      in_valid = 1'b0;
      checkOutput("req035_accepts", 64'(acc), 64'(20));
      checkOutput("req035_delivered", 64'(delivered - base), 64'(20));
      checkOutput("req035_consecutive", 64'(maxRun), 64'(20));

      // Reset mid-flight discards both queued vectors.
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         randomOperands();
         nextCycle();
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("req037_out_valid_now", 64'(out_valid), 64'(0));
      checkOutput("req037_in_ready_now", 64'(in_ready), 64'(0));
      checkOutput("req037_n_5_now", 64'(n_5), 64'(0));
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("req027_in_ready_release", 64'(in_ready), 64'(1));
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checkOutput("req037_no_ghosts", 64'(seen), 64'(0));

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         nextCycle();
         in_valid  = ($urandom_range(0, 99) < 70);
         randomOperands();
         out_ready = ($urandom_range(0, 99) < 60);
         cnt_clr   = ($urandom_range(0, 99) < 3);
      end
      nextCycle();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      bound = 0;
      while (q.size() != 0 && bound < 20) begin
         @(negedge clk);
         bound++;
      end
      checkOutput("final_drain", 64'(q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
